// File: rtl/clock24_pkg.sv
// rtl/clock24_pkg.sv - mode encoding, BCD field limits and BCD increment helper
package clock24_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    // BCD order matches numeric order, so >= also folds any out-of-range value back to zero
    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max);
        if (v >= max) begin
            return 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/bcd_wrap_cnt.sv
// rtl/bcd_wrap_cnt.sv - two-digit BCD counter wrapping at a programmable maximum
module bcd_wrap_cnt
    import clock24_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    input  logic [7:0] max,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 8'h00;
        end else if (inc) begin
            value_d = bcd_next(value_q, max);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= 8'h00;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc & ~clr & (value_q >= max);

endmodule

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - 24h clock mode FSM, setting and blanking; CLOCK_AUTO_REPEAT_EN adds held-UP repeat
module clock_mode_ctrl
    import clock24_pkg::*;
#(
    parameter logic BLANK_LEVEL = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN1HZ,
    input  logic       SIG2HZ,
    input  logic       BTN_MODE,
    input  logic       BTN_UP,
    output logic       PRESC_RST,
    output logic [1:0] MODE,
    output logic [7:0] HOUR,
    output logic [7:0] MIN,
    output logic [7:0] SEC,
    output logic       BLANK_H,
    output logic       BLANK_M
);

    mode_t mode_q, mode_d;
    logic  btn_mode_q, btn_mode_d;
    logic  btn_up_q, btn_up_d;
    logic  armed_q, armed_d;
    logic  presc_rst_q, presc_rst_d;

    logic mode_press, up_press, up_inc;
    logic is_run, is_set_hour, is_set_min;
    logic sec_inc, sec_clr, min_inc, hour_inc;
    logic sec_carry, min_carry;

    assign is_run      = (mode_q == RUN);
    assign is_set_hour = (mode_q == SET_HOUR);
    assign is_set_min  = (mode_q == SET_MIN);

    // armed_q blocks the first post-reset cycle so a button held through reset is not seen as a press
    assign mode_press = armed_q & BTN_MODE & ~btn_mode_q;
    assign up_press   = armed_q & BTN_UP & ~btn_up_q & ~mode_press;

`ifdef CLOCK_AUTO_REPEAT_EN
    logic [1:0] hold_cnt_q, hold_cnt_d;
    logic       sig_q, sig_d;
    logic       repeat_inc;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        sig_d      = SIG2HZ;
        if (is_run || !BTN_UP || mode_press) begin
            hold_cnt_d = 2'd0;
        end else if (EN1HZ && hold_cnt_q != 2'd2) begin
            hold_cnt_d = hold_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_cnt_q <= 2'd0;
            sig_q      <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            sig_q      <= sig_d;
        end
    end

    // both SIG2HZ edges count, giving 4 repeats per second once the hold has matured
    assign repeat_inc = ~is_run & BTN_UP & ~mode_press & (hold_cnt_q == 2'd2) & (SIG2HZ ^ sig_q);
    assign up_inc     = up_press | repeat_inc;
`else
    assign up_inc = up_press;
`endif

    always_comb begin
        mode_d      = mode_q;
        presc_rst_d = 1'b0;
        btn_mode_d  = BTN_MODE;
        btn_up_d    = BTN_UP;
        armed_d     = 1'b1;
        if (mode_press) begin
            case (mode_q)
                RUN:      mode_d = SET_HOUR;
                SET_HOUR: mode_d = SET_MIN;
                SET_MIN: begin
                    mode_d      = RUN;
                    presc_rst_d = 1'b1;
                end
                default:  mode_d = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q      <= RUN;
            presc_rst_q <= 1'b0;
            btn_mode_q  <= 1'b0;
            btn_up_q    <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            presc_rst_q <= presc_rst_d;
            btn_mode_q  <= btn_mode_d;
            btn_up_q    <= btn_up_d;
            armed_q     <= armed_d;
        end
    end

    // leaving RUN clears SEC and swallows a coincident tick
    assign sec_clr  = is_run & mode_press;
    assign sec_inc  = is_run & EN1HZ & ~mode_press;
    assign min_inc  = sec_carry | (is_set_min & up_inc);
    assign hour_inc = (is_run & min_carry) | (is_set_hour & up_inc);

    bcd_wrap_cnt u_sec (
        .clk   (CLK),
        .rst   (RST),
        .inc   (sec_inc),
        .clr   (sec_clr),
        .max   (SEC_MAX),
        .value (SEC),
        .carry (sec_carry)
    );

    bcd_wrap_cnt u_min (
        .clk   (CLK),
        .rst   (RST),
        .inc   (min_inc),
        .clr   (1'b0),
        .max   (MIN_MAX),
        .value (MIN),
        .carry (min_carry)
    );

    bcd_wrap_cnt u_hour (
        .clk   (CLK),
        .rst   (RST),
        .inc   (hour_inc),
        .clr   (1'b0),
        .max   (HOUR_MAX),
        .value (HOUR),
        .carry ()
    );

    assign MODE      = mode_q;
    assign PRESC_RST = presc_rst_q;
    assign BLANK_H   = is_set_hour & (SIG2HZ == BLANK_LEVEL);
    assign BLANK_M   = is_set_min & (SIG2HZ == BLANK_LEVEL);

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - directed self-checking bench for clock_mode_ctrl
module tb_clock_mode_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN1HZ;
    logic       SIG2HZ;
    logic       BTN_MODE;
    logic       BTN_UP;
    logic       PRESC_RST;
    logic [1:0] MODE;
    logic [7:0] HOUR;
    logic [7:0] MIN;
    logic [7:0] SEC;
    logic       BLANK_H;
    logic       BLANK_M;

    int tests = 0;
    int fails = 0;

    clock_mode_ctrl #(.BLANK_LEVEL(1'b1)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN1HZ     (EN1HZ),
        .SIG2HZ    (SIG2HZ),
        .BTN_MODE  (BTN_MODE),
        .BTN_UP    (BTN_UP),
        .PRESC_RST (PRESC_RST),
        .MODE      (MODE),
        .HOUR      (HOUR),
        .MIN       (MIN),
        .SEC       (SEC),
        .BLANK_H   (BLANK_H),
        .BLANK_M   (BLANK_M)
    );

    always #10 CLK = ~CLK;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic press_mode();
        BTN_MODE = 1'b1;
        cyc(1);
        BTN_MODE = 1'b0;
        cyc(1);
    endtask

    task automatic press_up(input int n);
        for (int i = 0; i < n; i++) begin
            BTN_UP = 1'b1;
            cyc(1);
            BTN_UP = 1'b0;
            cyc(1);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            EN1HZ = 1'b1;
            cyc(1);
            EN1HZ = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; BTN_MODE = 1'b1; BTN_UP = 1'b1; EN1HZ = 1'b0; SIG2HZ = 1'b0;
        cyc(3);
        tests++;
        if (MODE !== 2'd0 || {HOUR, MIN, SEC} !== 24'h000000 || PRESC_RST !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: mode=%0d time=%h:%h:%h presc=%b, want 0 00:00:00 0", MODE, HOUR, MIN, SEC, PRESC_RST);
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            tests++;
            if (MODE !== 2'd0 || {HOUR, MIN, SEC} !== 24'h000000) begin
                fails++;
                $display("FAIL held_through_reset: cyc %0d mode=%0d time=%h:%h:%h, want 0 00:00:00", i, MODE, HOUR, MIN, SEC);
            end
        end
        BTN_MODE = 1'b0; BTN_UP = 1'b0;
        cyc(1);
        tests++;
        if (BLANK_H !== 1'b0 || BLANK_M !== 1'b0) begin
            fails++;
            $display("FAIL blank_in_run: bh=%b bm=%b, want 0 0", BLANK_H, BLANK_M);
        end
    endtask

    task automatic test_set_and_rollover();
        press_mode();
        press_up(23);
        tests++;
        if (MODE !== 2'd1 || HOUR !== 8'h23) begin
            fails++;
            $display("FAIL set_hour_23: mode=%0d hour=%h, want 1 23", MODE, HOUR);
        end
        SIG2HZ = 1'b1; #1;
        tests++;
        if (BLANK_H !== 1'b1 || BLANK_M !== 1'b0) begin
            fails++;
            $display("FAIL blank_h_on: bh=%b bm=%b, want 1 0", BLANK_H, BLANK_M);
        end
        SIG2HZ = 1'b0; #1;
        tests++;
        if (BLANK_H !== 1'b0) begin
            fails++;
            $display("FAIL blank_h_off: bh=%b, want 0", BLANK_H);
        end
        press_up(1);
        tests++;
        if (HOUR !== 8'h00 || MIN !== 8'h00) begin
            fails++;
            $display("FAIL hour_wrap: hour=%h min=%h, want 00 00", HOUR, MIN);
        end
        press_up(23);
        press_mode();
        SIG2HZ = 1'b1; #1;
        tests++;
        if (MODE !== 2'd2 || BLANK_M !== 1'b1 || BLANK_H !== 1'b0) begin
            fails++;
            $display("FAIL set_min_blank: mode=%0d bm=%b bh=%b, want 2 1 0", MODE, BLANK_M, BLANK_H);
        end
        SIG2HZ = 1'b0;
        press_up(59);
        tests++;
        if (MIN !== 8'h59) begin
            fails++;
            $display("FAIL set_min_59: min=%h, want 59", MIN);
        end
        press_up(1);
        tests++;
        if (MIN !== 8'h00 || HOUR !== 8'h23) begin
            fails++;
            $display("FAIL min_wrap_no_carry: hour=%h min=%h, want 23 00", HOUR, MIN);
        end
        press_up(59);
        BTN_MODE = 1'b1;
        cyc(1);
        BTN_MODE = 1'b0;
        tests++;
        if (MODE !== 2'd0 || PRESC_RST !== 1'b1) begin
            fails++;
            $display("FAIL exit_presc: mode=%0d presc=%b, want 0 1", MODE, PRESC_RST);
        end
        cyc(1);
        tests++;
        if (PRESC_RST !== 1'b0) begin
            fails++;
            $display("FAIL presc_one_cycle: presc=%b, want 0", PRESC_RST);
        end
        tick(58);
        tests++;
        if ({HOUR, MIN, SEC} !== 24'h235958) begin
            fails++;
            $display("FAIL preload: time=%h:%h:%h, want 23:59:58", HOUR, MIN, SEC);
        end
        tick(1);
        tests++;
        if ({HOUR, MIN, SEC} !== 24'h235959) begin
            fails++;
            $display("FAIL tick_59: time=%h:%h:%h, want 23:59:59", HOUR, MIN, SEC);
        end
        tick(1);
        tests++;
        if ({HOUR, MIN, SEC} !== 24'h000000) begin
            fails++;
            $display("FAIL midnight: time=%h:%h:%h, want 00:00:00", HOUR, MIN, SEC);
        end
    endtask

    task automatic test_freeze();
        press_mode();
        press_up(12);
        press_mode();
        press_up(34);
        press_mode();
        tick(56);
        tests++;
        if ({HOUR, MIN, SEC} !== 24'h123456) begin
            fails++;
            $display("FAIL run_123456: time=%h:%h:%h, want 12:34:56", HOUR, MIN, SEC);
        end
        BTN_MODE = 1'b1; EN1HZ = 1'b1;
        cyc(1);
        BTN_MODE = 1'b0; EN1HZ = 1'b0;
        tests++;
        if (MODE !== 2'd1 || SEC !== 8'h00) begin
            fails++;
            $display("FAIL enter_set_clr: mode=%0d sec=%h, want 1 00", MODE, SEC);
        end
        cyc(1);
        tick(3);
        tests++;
        if ({HOUR, MIN, SEC} !== 24'h123400 || MODE !== 2'd1) begin
            fails++;
            $display("FAIL frozen: mode=%0d time=%h:%h:%h, want 1 12:34:00", MODE, HOUR, MIN, SEC);
        end
    endtask

    task automatic test_mode_up_same_cycle();
        int presc_cnt;
        press_up(17);
        tests++;
        if (HOUR !== 8'h05) begin
            fails++;
            $display("FAIL hour_05: hour=%h, want 05", HOUR);
        end
        BTN_MODE = 1'b1; BTN_UP = 1'b1;
        cyc(1);
        BTN_MODE = 1'b0; BTN_UP = 1'b0;
        tests++;
        if (MODE !== 2'd2 || HOUR !== 8'h05 || MIN !== 8'h34) begin
            fails++;
            $display("FAIL mode_wins: mode=%0d hour=%h min=%h, want 2 05 34", MODE, HOUR, MIN);
        end
        cyc(1);
        presc_cnt = 0;
        BTN_MODE = 1'b1;
        cyc(1);
        BTN_MODE = 1'b0;
        if (PRESC_RST === 1'b1) presc_cnt++;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (PRESC_RST === 1'b1) presc_cnt++;
        end
        tests++;
        if (MODE !== 2'd0 || presc_cnt != 1) begin
            fails++;
            $display("FAIL exit_single_presc: mode=%0d presc_cycles=%0d, want 0 1", MODE, presc_cnt);
        end
    endtask

    task automatic test_hold();
        logic [7:0] exp_min;
        press_mode();
        press_mode();
        press_up(26);
        tests++;
        if (MODE !== 2'd2 || MIN !== 8'h00) begin
            fails++;
            $display("FAIL hold_start: mode=%0d min=%h, want 2 00", MODE, MIN);
        end
        BTN_UP = 1'b1;
        cyc(1);
        tests++;
        if (MIN !== 8'h01) begin
            fails++;
            $display("FAIL hold_first: min=%h, want 01", MIN);
        end
        for (int s = 0; s < 5; s++) begin
            tick(1);
            for (int k = 0; k < 4; k++) begin
                cyc(3);
                SIG2HZ = ~SIG2HZ;
                cyc(1);
            end
        end
        BTN_UP = 1'b0;
        cyc(1);
`ifdef CLOCK_AUTO_REPEAT_EN
        exp_min = 8'h17;
`else
        exp_min = 8'h01;
`endif
        tests++;
        if (MIN !== exp_min || HOUR !== 8'h05) begin
            fails++;
            $display("FAIL hold_5s: hour=%h min=%h, want 05 %h", HOUR, MIN, exp_min);
        end
    endtask

    task automatic test_reset_mid_setting();
        BTN_UP = 1'b1; RST = 1'b1;
        cyc(2);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            tests++;
            if (MODE !== 2'd0 || {HOUR, MIN, SEC} !== 24'h000000 || PRESC_RST !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_set: cyc %0d mode=%0d time=%h:%h:%h presc=%b, want 0 00:00:00 0", i, MODE, HOUR, MIN, SEC, PRESC_RST);
            end
        end
        BTN_UP = 1'b0;
        cyc(1);
    endtask

    initial begin
        RST = 1'b1; EN1HZ = 1'b0; SIG2HZ = 1'b0; BTN_MODE = 1'b0; BTN_UP = 1'b0;
        test_reset();
        test_set_and_rollover();
        test_freeze();
        test_mode_up_same_cycle();
        test_hold();
        test_reset_mid_setting();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
